// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped timer: register map, CTRL field
// layout, mode encodings and the timer FSM state encoding.
package mmio_pkg;

    // Word offsets of the timer registers (byte address bits [3:2]).
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    // MODE encodings; 2 and 3 fall back to one-shot behaviour.
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_AUTO    = 2'd1;

    // Timer sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_DONE = 2'd3
    } tc_state_e;

    // Assemble the architecturally visible CTRL word; upper bits read as 0.
    function automatic logic [31:0] ctrl_pack(input logic en, input logic [1:0] mode,
                                              input logic im);
        logic [31:0] word_v;
        word_v                              = 32'd0;
        word_v[CTRL_EN_BIT]                 = en;
        word_v[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode;
        word_v[CTRL_IM_BIT]                 = im;
        return word_v;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with a maskable, sticky interrupt.
// Three word registers (CTRL, PRESET, COUNT) are decoded from the CPU's
// data-memory stage; the counter reloads from PRESET and flags expiry.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq
);

    // Architectural state.
    logic        en_r;
    logic [1:0]  mode_r;
    logic        im_r;
    logic [31:0] preset_r;
    logic [31:0] count_r;
    logic        irq_pend_r;
    tc_state_e   state_r;

    // Decode and FSM control strobes.
    tc_state_e   state_nxt_s;
    logic [1:0]  reg_off_s;
    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        load_s;
    logic        dec_s;
    logic        zero_s;
    logic        set_pend_s;
    logic        clr_en_s;
    logic [31:0] rdata_s;

    assign reg_off_s   = 2'(addr);
    assign wr_ctrl_s   = sel & we & (reg_off_s == TC_CTRL);
    assign wr_preset_s = sel & we & (reg_off_s == TC_PRESET);

    // Timer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath control for the count sequence.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        dec_s       = 1'b0;
        zero_s      = 1'b0;
        set_pend_s  = 1'b0;
        clr_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en_r) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_s      = 1'b1;
                state_nxt_s = ST_CNT;
            end
            ST_CNT: begin
                // A paused count keeps its value so it can be inspected.
                if (!en_r) begin
                    state_nxt_s = ST_IDLE;
                end else if (count_r <= 32'd1) begin
                    // Saturate at zero so a zero preset still expires once.
                    zero_s      = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    dec_s       = 1'b1;
                    state_nxt_s = ST_CNT;
                end
            end
            ST_DONE: begin
                set_pend_s = 1'b1;
                if (mode_r == MODE_AUTO) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    clr_en_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Register file: bus writes, counter datapath and the sticky pend flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r       <= 1'b0;
            mode_r     <= 2'd0;
            im_r       <= 1'b0;
            preset_r   <= 32'd0;
            count_r    <= 32'd0;
            irq_pend_r <= 1'b0;
        end else begin
            // A software CTRL write overrides the one-shot auto-disable.
            if (wr_ctrl_s) begin
                en_r   <= wdata[CTRL_EN_BIT];
                mode_r <= wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
                im_r   <= wdata[CTRL_IM_BIT];
            end else if (clr_en_s) begin
                en_r <= 1'b0;
            end

            // PRESET is only sampled in LOAD, so mid-count writes are deferred.
            if (wr_preset_s) begin
                preset_r <= wdata;
            end

            if (load_s) begin
                count_r <= preset_r;
            end else if (dec_s) begin
                count_r <= count_r - 32'd1;
            end else if (zero_s) begin
                count_r <= 32'd0;
            end

            // Acknowledge by CTRL/PRESET write takes priority over a new expiry.
            if (wr_ctrl_s || wr_preset_s) begin
                irq_pend_r <= 1'b0;
            end else if (set_pend_s) begin
                irq_pend_r <= 1'b1;
            end
        end
    end

    // Read mux; unmapped offset and CTRL upper bits read as zero.
    always_comb begin
        rdata_s = 32'd0;
        case (reg_off_s)
            TC_CTRL:   rdata_s = ctrl_pack(en_r, mode_r, im_r);
            TC_PRESET: rdata_s = preset_r;
            TC_COUNT:  rdata_s = count_r;
            default:   rdata_s = 32'd0;
        endcase
    end

    assign rdata = rdata_s;
    assign irq   = irq_pend_r & im_r;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer: reset, one-shot, auto-reload,
// masking with zero preset, pause/resume and access-boundary behaviour.
module tb_mmio_timer;
    import mmio_pkg::*;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_tests;
    int n_fail;

    mmio_timer #(.ADDR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        d = rdata;
        chk(tag, d, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        sel     = 1'b0;
        we      = 1'b0;
        addr    = 2'd0;
        wdata   = 32'd0;

        // Power-on reset.
        #1 reset = 1'b0;
        #1;
        chk_irq("rst_irq", 1'b0);
        chk_reg("rst_ctrl", TC_CTRL, 32'd0);
        chk_reg("rst_preset", TC_PRESET, 32'd0);
        chk_reg("rst_count", TC_COUNT, 32'd0);
        @(negedge clk) reset = 1'b1;
        tick(3);
        chk_reg("rst_idle_count", TC_COUNT, 32'd0);

        // One-shot, PRESET=3; same-cycle read sees the old PRESET.
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = TC_PRESET; wdata = 32'd3;
        #1;
        chk("os_old_read", rdata, 32'd0);
        @(posedge clk);
        #1;
        we = 1'b0;
        chk_reg("os_preset", TC_PRESET, 32'd3);
        wr(TC_CTRL, 32'h9);
        tick(2);
        chk_reg("os_cnt3", TC_COUNT, 32'd3);
        tick(1);
        chk_reg("os_cnt2", TC_COUNT, 32'd2);
        tick(1);
        chk_reg("os_cnt1", TC_COUNT, 32'd1);
        tick(1);
        chk_reg("os_cnt0", TC_COUNT, 32'd0);
        chk_irq("os_irq_e5", 1'b0);
        tick(1);
        chk_irq("os_irq_e6", 1'b1);
        chk_reg("os_ctrl_en_clr", TC_CTRL, 32'h8);
        tick(2);
        chk_irq("os_irq_sticky", 1'b1);
        chk_reg("os_count_hold", TC_COUNT, 32'd0);
        wr(TC_CTRL, 32'h8);
        chk_irq("os_irq_ack", 1'b0);

        // Auto-reload, PRESET=2: DONE every 4 edges.
        wr(TC_PRESET, 32'd2);
        wr(TC_CTRL, 32'hB);
        tick(2);
        chk_reg("ar_cnt_e2", TC_COUNT, 32'd2);
        tick(2);
        chk_reg("ar_cnt_e4", TC_COUNT, 32'd0);
        chk_irq("ar_irq_e4", 1'b0);
        tick(1);
        chk_irq("ar_irq_e5", 1'b1);
        tick(1);
        chk_reg("ar_reload_e6", TC_COUNT, 32'd2);
        tick(4);
        chk_reg("ar_reload_e10", TC_COUNT, 32'd2);
        chk_irq("ar_irq_e10", 1'b1);
        chk_reg("ar_ctrl", TC_CTRL, 32'hB);
        wr(TC_PRESET, 32'd2);
        chk_irq("ar_preset_ack", 1'b0);
        chk_reg("ar_cnt_e11", TC_COUNT, 32'd1);
        wr(TC_CTRL, 32'h0);
        tick(4);
        chk_reg("ar_stop_count", TC_COUNT, 32'd0);
        chk_reg("ar_stop_ctrl", TC_CTRL, 32'h0);
        chk_irq("ar_stop_irq", 1'b0);

        // Masked expiry with zero preset; a CTRL write then clears the pend.
        wr(TC_PRESET, 32'd0);
        wr(TC_CTRL, 32'h1);
        tick(4);
        chk_irq("mz_irq_masked", 1'b0);
        chk_reg("mz_ctrl_en_clr", TC_CTRL, 32'h0);
        chk_reg("mz_count", TC_COUNT, 32'd0);
        wr(TC_CTRL, 32'h8);
        chk_irq("mz_irq_unmask", 1'b0);
        chk_reg("mz_ctrl", TC_CTRL, 32'h8);

        // Pause at COUNT=7 and boundary accesses.
        wr(TC_PRESET, 32'd10);
        wr(TC_CTRL, 32'h1);
        tick(4);
        chk_reg("pz_cnt8", TC_COUNT, 32'd8);
        wr(TC_CTRL, 32'h0);
        chk_reg("pz_cnt7", TC_COUNT, 32'd7);
        tick(3);
        chk_reg("pz_hold7", TC_COUNT, 32'd7);
        wr(TC_COUNT, 32'h1234);
        chk_reg("pz_count_ro", TC_COUNT, 32'd7);
        wr(2'd3, 32'hFFFF_FFFF);
        chk_reg("pz_off3", 2'd3, 32'd0);
        @(negedge clk);
        sel = 1'b0; we = 1'b1; addr = TC_PRESET; wdata = 32'hDEAD;
        @(posedge clk);
        #1;
        we = 1'b0;
        chk_reg("pz_nosel", TC_PRESET, 32'd10);
        wr(TC_CTRL, 32'hFFFF_FFF1);
        chk_reg("pz_ctrl_hibits", TC_CTRL, 32'h1);
        tick(2);
        chk_reg("pz_reload10", TC_COUNT, 32'd10);
        tick(1);
        chk_reg("pz_cnt9", TC_COUNT, 32'd9);
        wr(TC_CTRL, 32'h0);
        tick(2);

        // Asynchronous reset mid-count with a live interrupt.
        wr(TC_PRESET, 32'd5);
        wr(TC_CTRL, 32'hB);
        tick(10);
        chk_reg("mr_cnt_e10", TC_COUNT, 32'd4);
        chk_irq("mr_irq_pre", 1'b1);
        #10 reset = 1'b0;
        #1;
        chk_irq("mr_irq_async", 1'b0);
        chk_reg("mr_ctrl", TC_CTRL, 32'd0);
        chk_reg("mr_preset", TC_PRESET, 32'd0);
        chk_reg("mr_count", TC_COUNT, 32'd0);
        @(negedge clk) reset = 1'b1;
        tick(5);
        chk_reg("mr_idle_count", TC_COUNT, 32'd0);
        chk_reg("mr_idle_ctrl", TC_CTRL, 32'd0);
        chk_irq("mr_idle_irq", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
